// File: rtl/digit_entry_sequencer_if.sv
// digit_entry_sequencer_if
// Bundles the key-entry side of the digit sequencer.
//   keys    : raw asynchronous key lines, bit k = key k
//   clear   : synchronous request to discard a partial entry
//   digit   : one-hot replayed digit during a burst, else zero
//   burst   : high on each replay cycle
//   count   : number of digits currently held
//   timeout : one-cycle pulse when a partial entry expires
// master drives keys/clear (stimulus side); slave is the sequencer.
interface digit_entry_sequencer_if #(
  parameter int DIGITS = 3
);
  localparam int CW = $clog2(DIGITS + 1);

  logic [9:0]    keys;
  logic          clear;
  logic [9:0]    digit;
  logic          burst;
  logic [CW-1:0] count;
  logic          timeout;

  modport master (output keys, clear, input digit, burst, count, timeout);
  modport slave  (input keys, clear, output digit, burst, count, timeout);
endinterface

// File: rtl/digit_entry_sequencer.sv
// digit_entry_sequencer
// Conditions ten raw key lines (2-flop synchroniser + stability debounce),
// collects DIGITS one-hot key presses into a buffer, then replays the buffer
// on DIGITS consecutive cycles for the combination lock's digit input.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : digit_entry_sequencer_if.slave (keys, clear in; digit, burst,
//         count, timeout out)
module digit_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int DIGITS          = 3
) (
  input logic                    clk,
  input logic                    rst,
  digit_entry_sequencer_if.slave bus
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGITS - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {COLLECT, BURST} state_t;

  function automatic logic is_one_hot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  state_t                  state, state_next;
  logic [9:0]              sync_p0, sync_p1, ks_p2;
  logic [SW-1:0]           stab;
  logic [9:0]              kd, kd_last;
  logic [CW-1:0]           count;
  logic [CW-1:0]           idx;
  logic [TW-1:0]           tmo_cnt;
  logic [DIGITS-1:0][9:0]  store;
  logic                    timeout;
  logic                    press;
  logic                    store_en, wipe, expire;
  logic [9:0]              digit_c;

  // Stage p0/p1: synchroniser; p2: previous ks for the stability compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      ks_p2   <= '0;
      stab    <= '0;
      kd      <= '0;
      kd_last <= '0;
    end else begin
      sync_p0 <= bus.keys;
      sync_p1 <= sync_p0;
      ks_p2   <= sync_p1;
      kd_last <= kd;
      if (sync_p1 != ks_p2)
        stab <= '0;
      else if (stab == STAB_LAST)
        kd <= sync_p1;
      else
        stab <= stab + SW'(1);
    end
  end

  // A press is only an edge out of all-zero into exactly one key; a multi-key
  // vector or a change between non-zero vectors never qualifies, which is
  // what enforces release-before-next-press and blocks auto-repeat.
  assign press = (kd_last == 10'd0) && is_one_hot(kd);

  always_comb begin
    state_next = state;
    store_en   = 1'b0;
    wipe       = 1'b0;
    expire     = 1'b0;
    case (state)
      COLLECT: begin
        if (bus.clear) begin
          wipe = 1'b1;
        end else if (press) begin
          store_en = 1'b1;
          if (count == CNT_LAST)
            state_next = BURST;
        end else if (count != '0 && tmo_cnt == TMO_LAST) begin
          wipe   = 1'b1;
          expire = 1'b1;
        end
      end
      BURST: begin
        if (idx == CNT_LAST) begin
          wipe       = 1'b1;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= COLLECT;
      count   <= '0;
      idx     <= '0;
      tmo_cnt <= '0;
      store   <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      timeout <= expire;
      if (wipe) begin
        count   <= '0;
        store   <= '0;
        tmo_cnt <= '0;
      end else if (store_en) begin
        for (int i = 0; i < DIGITS; i++)
          if (count == CW'(i)) store[i] <= kd;
        count   <= count + CW'(1);
        tmo_cnt <= '0;
      end else if (state == COLLECT && count != '0) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (state == BURST && idx != CNT_LAST)
        idx <= idx + CW'(1);
      else
        idx <= '0;
    end
  end

  always_comb begin
    digit_c = '0;
    if (state == BURST)
      for (int i = 0; i < DIGITS; i++)
        if (idx == CW'(i)) digit_c = store[i];
  end

  assign bus.digit   = digit_c;
  assign bus.burst   = (state == BURST);
  assign bus.count   = count;
  assign bus.timeout = timeout;

endmodule

// File: tb/tb_digit_entry_sequencer.sv
// tb_digit_entry_sequencer
// Table-driven directed steps, hand-written multi-cycle sequences (bounce,
// held key through replay, reset mid-replay) and a randomized phase checked
// against a digit-list reference model.
module tb_digit_entry_sequencer;

  localparam int DEB  = 4;
  localparam int TMO  = 60;
  localparam int DIGS = 3;

  logic clk;
  logic rst;

  digit_entry_sequencer_if #(.DIGITS(DIGS)) bus ();

  digit_entry_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .DIGITS         (DIGS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Inputs change right after a falling edge and hold for n rising edges.
  task automatic drive(input logic [9:0] k, input logic c, input int n);
    bus.keys  = k;
    bus.clear = c;
    repeat (n) @(negedge clk);
  endtask

  // Burst monitor: collects completed replays and counts invariant breaks.
  logic [9:0] seen_q[$];
  logic [9:0] cur_q[$];
  int burst_runs = 0;
  int tmo_seen   = 0;
  int bad        = 0;

  always @(negedge clk) begin
    if (!rst) begin
      cur_q.delete();
    end else begin
      if (bus.burst) begin
        if (!$onehot(bus.digit) || int'(bus.count) != DIGS) bad++;
        cur_q.push_back(bus.digit);
      end else begin
        if (bus.digit != 10'h0) bad++;
        if (cur_q.size() != 0) begin
          if (cur_q.size() != DIGS) bad++;
          foreach (cur_q[i]) seen_q.push_back(cur_q[i]);
          burst_runs++;
          cur_q.delete();
        end
      end
      if (bus.timeout) tmo_seen++;
    end
  end

  typedef struct {
    logic [9:0] keys;
    logic       clear;
    int         cycles;
    int         exp_count;
  } step_t;

  localparam int NSTEP = 22;
  step_t steps [NSTEP];

  logic [9:0] exp_dir [6];
  logic [9:0] model_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] kv;
  int base, tmo_base, runs_base, exp_tmo, act, k, a, b, h, r, found;

  initial begin
    steps[0]  = '{10'h004, 1'b0, 12, 1};
    steps[1]  = '{10'h000, 1'b0, 12, 1};
    steps[2]  = '{10'h080, 1'b0, 12, 2};
    steps[3]  = '{10'h000, 1'b0, 12, 2};
    steps[4]  = '{10'h008, 1'b0, 14, 0};
    steps[5]  = '{10'h000, 1'b0, 12, 0};
    steps[6]  = '{10'h012, 1'b0, 14, 0};
    steps[7]  = '{10'h000, 1'b0, 12, 0};
    steps[8]  = '{10'h040, 1'b0, 14, 1};
    steps[9]  = '{10'h000, 1'b0, 12, 1};
    steps[10] = '{10'h001, 1'b0, 14, 2};
    steps[11] = '{10'h000, 1'b0, 12, 2};
    steps[12] = '{10'h200, 1'b0, 14, 0};
    steps[13] = '{10'h000, 1'b0, 12, 0};
    steps[14] = '{10'h200, 1'b0, 14, 1};
    steps[15] = '{10'h000, 1'b0, TMO + 20, 0};
    steps[16] = '{10'h008, 1'b0, 14, 1};
    steps[17] = '{10'h000, 1'b0, 12, 1};
    steps[18] = '{10'h010, 1'b0, 14, 2};
    steps[19] = '{10'h000, 1'b0, 12, 2};
    steps[20] = '{10'h020, 1'b1, 14, 0};
    steps[21] = '{10'h000, 1'b0, TMO + 20, 0};
    exp_dir[0] = 10'h004; exp_dir[1] = 10'h080; exp_dir[2] = 10'h008;
    exp_dir[3] = 10'h040; exp_dir[4] = 10'h001; exp_dir[5] = 10'h200;

    rst = 1'b0;
    bus.keys = '0;
    bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_digit",   int'(bus.digit),   0);
    check("reset_burst",   int'(bus.burst),   0);
    check("reset_count",   int'(bus.count),   0);
    check("reset_timeout", int'(bus.timeout), 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int s = 0; s < NSTEP; s++) begin
      drive(steps[s].keys, steps[s].clear, steps[s].cycles);
      check($sformatf("step%0d_count", s), int'(bus.count), steps[s].exp_count);
    end
    check("dir_burst_runs", burst_runs, 2);
    check("dir_digits_len", seen_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < seen_q.size()) check($sformatf("dir_digit%0d", i), int'(seen_q[i]), int'(exp_dir[i]));
    check("dir_timeouts", tmo_seen, 1);

    // Key 5 bouncing, then stable
    drive(10'h020, 1'b0, 1);
    drive(10'h000, 1'b0, 1);
    drive(10'h020, 1'b0, 14);
    check("bounce_count", int'(bus.count), 1);
    drive(10'h000, 1'b0, 12);
    drive(10'h000, 1'b1, 1);
    drive(10'h000, 1'b0, 2);
    check("bounce_clear_count", int'(bus.count), 0);

    // Third key held through the replay and well beyond
    runs_base = burst_runs;
    drive(10'h002, 1'b0, 14); drive(10'h000, 1'b0, 12);
    drive(10'h100, 1'b0, 14); drive(10'h000, 1'b0, 12);
    drive(10'h004, 1'b0, 50);
    check("held_count", int'(bus.count), 0);
    check("held_one_burst", burst_runs - runs_base, 1);
    drive(10'h000, 1'b0, 12);
    check("held_release_count", int'(bus.count), 0);

    // Reset pulsed during a replay
    runs_base = burst_runs;
    drive(10'h002, 1'b0, 14); drive(10'h000, 1'b0, 12);
    drive(10'h100, 1'b0, 14); drive(10'h000, 1'b0, 12);
    bus.keys = 10'h004;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (bus.burst) found = 1;
    end
    check("rstmid_burst_seen", found, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmid_digit", int'(bus.digit), 0);
    check("rstmid_burst", int'(bus.burst), 0);
    check("rstmid_count", int'(bus.count), 0);
    bus.keys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(10'h000, 1'b0, 30);
    check("rstmid_after_count", int'(bus.count), 0);
    check("rstmid_no_burst", burst_runs - runs_base, 0);

    // Randomized phase against the digit-list model
    base = seen_q.size();
    tmo_base = tmo_seen;
    exp_tmo = 0;
    for (int n = 0; n < 60; n++) begin
      act = $urandom_range(0, 9);
      if (act == 6 && model_q.size() != 0) act = 7;
      h = $urandom_range(12, 18);
      r = $urandom_range(12, 18);
      if (act <= 5 || act == 9) begin
        k = $urandom_range(0, 9);
        kv = 10'b1 << k;
        if (act == 9) begin
          drive(kv, 1'b0, 1);
          drive(10'h000, 1'b0, 1);
        end
        drive(kv, 1'b0, h);
        model_q.push_back(kv);
        if (model_q.size() == DIGS) begin
          foreach (model_q[i]) exp_q.push_back(model_q[i]);
          model_q.delete();
        end
        check($sformatf("rand%0d_press_count", n), int'(bus.count), model_q.size());
        drive(10'h000, 1'b0, r);
      end else if (act == 6) begin
        a = $urandom_range(0, 9);
        b = (a + 1 + $urandom_range(0, 8)) % 10;
        kv = (10'b1 << a) | (10'b1 << b);
        drive(kv, 1'b0, h);
        check($sformatf("rand%0d_multi_count", n), int'(bus.count), model_q.size());
        drive(10'h000, 1'b0, r);
      end else if (act == 7) begin
        drive(10'h000, 1'b1, 1);
        drive(10'h000, 1'b0, 3);
        model_q.delete();
        check($sformatf("rand%0d_clear_count", n), int'(bus.count), 0);
      end else begin
        drive(10'h000, 1'b0, TMO + 20);
        if (model_q.size() != 0) exp_tmo++;
        model_q.delete();
        check($sformatf("rand%0d_idle_count", n), int'(bus.count), 0);
      end
    end
    check("rand_digits_len", seen_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < seen_q.size())
        check($sformatf("rand_digit%0d", i), int'(seen_q[base + i]), int'(exp_q[i]));
    check("rand_timeouts", tmo_seen - tmo_base, exp_tmo);
    check("output_invariants", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
